// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the audio mixer.
// Holds the sequencer state enum, the sample width and the output clamp limits.
// No logic; imported by the controller and the saturator.
package audio_mix_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  // Sequencer phase; the source index travels alongside in its own register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_SAT  = 2'd3
  } state_t;

endpackage

// File: rtl/audio_mix_sat.sv
// Clamps the wide mix accumulator into a 16-bit signed sample.
// Latency: combinational.
// Backpressure: none; pure function of the accumulator.
module audio_mix_sat
  import audio_mix_pkg::*;
#(
  parameter int AW = 23
) (
  input  logic signed [AW-1:0]       acc,
  output logic        [SAMPLE_W-1:0] sat
);

  // Clamp to the signed 16-bit range, pass through otherwise.
  always_comb begin
    if (acc > AW'(SAT_MAX)) begin
      sat = SAT_MAX;
    end else if (acc < AW'(SAT_MIN)) begin
      sat = SAT_MIN;
    end else begin
      sat = acc[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/audio_mix_ctrl.sv
// Mixes NSRC gain-scaled sample sources into one stream for the DAC serializer.
// Latency: a mix is ready 2*NSRC+1 cycles after dac_req and is output on the following dac_req.
// Backpressure: none; the serializer's request is never stalled, a premature request outputs the stale mix.
module audio_mix_ctrl
  import audio_mix_pkg::*;
#(
  parameter int NSRC = 3,
  parameter int VOLW = 4
) (
  input  logic                       clk_1p536m,
  input  logic                       rst_n,
  input  logic                       dac_req,
  output logic [SAMPLE_W-1:0]        dac_data,
  output logic                       dac_chan,
  input  logic [NSRC-1:0]            src_empty,
  output logic [NSRC-1:0]            src_rd,
  input  logic [NSRC*SAMPLE_W-1:0]   src_data,
  input  logic [NSRC-1:0]            src_en,
  input  logic [NSRC*VOLW-1:0]       src_vol,
  input  logic                       mute,
  input  logic                       clr_status,
  output logic [NSRC-1:0]            underrun,
  output logic                       late
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int AW = SAMPLE_W + VOLW + $clog2(NSRC) + 1;
  localparam int PW = SAMPLE_W + VOLW + 1;

  state_t                    state;
  logic [IW-1:0]             idx;
  logic                      took;      // a read was issued for the current source
  logic                      miss;      // source enabled but its FIFO was empty
  logic                      next_chan;
  logic [SAMPLE_W-1:0]       next_r;
  logic signed [AW-1:0]      acc;
  logic [SAMPLE_W-1:0]       hold [NSRC][2];

  logic [SAMPLE_W-1:0]       cur_data;
  logic [VOLW-1:0]           cur_vol;
  logic [SAMPLE_W-1:0]       cap_sample;
  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      term;
  logic [SAMPLE_W-1:0]       sat_out;

  // Read strobe for the source being visited; only one index is live so at most one bit is set.
  always_comb begin
    src_rd = '0;
    if (state == ST_RD && src_en[idx] && !src_empty[idx]) begin
      src_rd[idx] = 1'b1;
    end
  end

  // Scaled contribution of the current source: fresh data if read, otherwise the held sample.
  always_comb begin
    cur_data   = src_data[idx*SAMPLE_W +: SAMPLE_W];
    cur_vol    = src_vol[idx*VOLW +: VOLW];
    cap_sample = took ? cur_data : hold[idx][next_chan];
    prod       = PW'($signed(cap_sample)) * PW'($signed({1'b0, cur_vol}));
    term       = AW'(prod >>> VOLW);
  end

  audio_mix_sat #(.AW(AW)) u_sat (
    .acc (acc),
    .sat (sat_out)
  );

  // Sequencer, sample holds, output register and sticky status.
  always_ff @(posedge clk_1p536m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      took      <= 1'b0;
      miss      <= 1'b0;
      next_chan <= 1'b0;
      next_r    <= '0;
      acc       <= '0;
      dac_data  <= '0;
      dac_chan  <= 1'b0;
      underrun  <= '0;
      late      <= 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        hold[i][0] <= '0;
        hold[i][1] <= '0;
      end
    end else begin
      // Clear first so that any set below on the same edge takes priority.
      if (clr_status) begin
        underrun <= '0;
        late     <= 1'b0;
      end
      if (dac_req) begin
        // A request always outputs whatever mix is ready and restarts for the other channel.
        dac_data  <= next_r;
        dac_chan  <= next_chan;
        next_chan <= ~next_chan;
        acc       <= '0;
        idx       <= '0;
        state     <= ST_RD;
        if (state != ST_IDLE) begin
          late <= 1'b1;
        end
      end else begin
        case (state)
          ST_RD: begin
            took  <= src_rd[idx];
            miss  <= src_en[idx] & src_empty[idx];
            state <= ST_CAP;
          end
          ST_CAP: begin
            if (took) begin
              hold[idx][next_chan] <= cur_data;
              acc                  <= acc + term;
            end else if (miss) begin
              acc           <= acc + term;
              underrun[idx] <= 1'b1;
            end
            if (idx == IW'(NSRC - 1)) begin
              state <= ST_SAT;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD;
            end
          end
          ST_SAT: begin
            next_r <= mute ? '0 : sat_out;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_mix_ctrl.sv
// Self-checking bench for audio_mix_ctrl: directed scenarios followed by randomized traffic.
// Expected outputs come from a request-level model of the mixer and are queued at request time.
// A negedge monitor pops and compares whenever the DUT has taken a request.
module tb_audio_mix_ctrl;

  localparam int NSRC = 3;
  localparam int VOLW = 4;

  logic                   clk_1p536m = 1'b0;
  logic                   rst_n;
  logic                   dac_req;
  logic [15:0]            dac_data;
  logic                   dac_chan;
  logic [NSRC-1:0]        src_empty = '1;
  logic [NSRC-1:0]        src_rd;
  logic [NSRC*16-1:0]     src_data;
  logic [NSRC-1:0]        src_en;
  logic [NSRC*VOLW-1:0]   src_vol;
  logic                   mute;
  logic                   clr_status;
  logic [NSRC-1:0]        underrun;
  logic                   late;

  audio_mix_ctrl #(.NSRC(NSRC), .VOLW(VOLW)) dut (
    .clk_1p536m (clk_1p536m),
    .rst_n      (rst_n),
    .dac_req    (dac_req),
    .dac_data   (dac_data),
    .dac_chan   (dac_chan),
    .src_empty  (src_empty),
    .src_rd     (src_rd),
    .src_data   (src_data),
    .src_en     (src_en),
    .src_vol    (src_vol),
    .mute       (mute),
    .clr_status (clr_status),
    .underrun   (underrun),
    .late       (late)
  );

  always #5 clk_1p536m = ~clk_1p536m;

  int total = 0;
  int bad   = 0;

  // Source FIFOs as seen by the DUT, and the model's own copy of their contents.
  int fq [NSRC][$];
  int mq [NSRC][$];
  logic [15:0] sd [NSRC];
  logic [NSRC-1:0] rd_seen = '0;
  int rd_cnt [NSRC];

  // Scoreboard: {chan, data} expected per request.
  logic [16:0] exp_q [$];

  // Request-level model state.
  int m_hold [NSRC][2];
  int m_nr, m_pend;
  bit m_ch;
  bit [NSRC-1:0] m_und;
  bit m_late;
  int cyc = 0;
  int last_req = -100;

  always_comb begin
    for (int i = 0; i < NSRC; i++) src_data[i*16 +: 16] = sd[i];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_1p536m);
    #1;
  endtask

  initial forever begin
    @(posedge clk_1p536m);
    cyc++;
  end

  // FIFO behaviour: a strobe seen mid-cycle pops after the next edge, data then valid for a cycle.
  initial forever begin
    @(posedge clk_1p536m);
    #1;
    for (int i = 0; i < NSRC; i++) begin
      if (rd_seen[i] && fq[i].size() > 0) sd[i] = 16'(fq[i].pop_front());
      src_empty[i] = (fq[i].size() == 0);
    end
    rd_seen = '0;
  end

  // Read-strobe sanity: one-hot and only for enabled sources.
  initial forever begin
    @(negedge clk_1p536m);
    if (rst_n === 1'b1 && src_rd != '0) begin
      rd_seen = src_rd;
      check("rd_onehot", $countones(src_rd), 1);
      for (int i = 0; i < NSRC; i++) begin
        if (src_rd[i]) begin
          rd_cnt[i]++;
          check("rd_enabled", src_en[i], 1);
        end
      end
    end
  end

  // Monitor: after each edge that took a request, compare the presented sample.
  initial begin
    bit req_seen;
    logic [16:0] e;
    req_seen = 1'b0;
    forever begin
      @(negedge clk_1p536m);
      if (rst_n !== 1'b1) begin
        req_seen = 1'b0;
      end else begin
        if (req_seen) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("dac_data", dac_data, e[15:0]);
            check("dac_chan", dac_chan, e[16]);
          end
        end
        req_seen = dac_req;
      end
    end
  end

  task automatic push(input int i, input int v);
    fq[i].push_back(v);
    mq[i].push_back(v);
  endtask

  task automatic set_vol(input int i, input int v);
    src_vol[i*VOLW +: VOLW] = VOLW'(v);
  endtask

  // One request at the level of the mixer's contract: output the ready mix, then mix the other channel.
  task automatic model_req(input bit lt);
    int acc;
    int s;
    int v;
    if (!lt) m_nr = m_pend;
    exp_q.push_back({m_ch, 16'(m_nr)});
    m_ch = ~m_ch;
    if (lt) m_late = 1'b1;
    acc = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_en[i]) begin
        if (mq[i].size() > 0) m_hold[i][m_ch] = mq[i].pop_front();
        else m_und[i] = 1'b1;
        s = m_hold[i][m_ch];
        v = int'(src_vol[i*VOLW +: VOLW]);
        acc += (s * v) >>> VOLW;
      end
    end
    if (mute) m_pend = 0;
    else if (acc > 32767) m_pend = 32767;
    else if (acc < -32768) m_pend = -32768;
    else m_pend = acc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_hold[i][0] = 0;
      m_hold[i][1] = 0;
      fq[i].delete();
      mq[i].delete();
    end
    m_nr = 0; m_pend = 0; m_ch = 1'b0; m_und = '0; m_late = 1'b0;
    last_req = -100;
    exp_q.delete();
  endtask

  task automatic issue_req();
    bit lt;
    lt = (cyc - last_req) < 8;
    dac_req = 1'b1;
    model_req(lt);
    last_req = cyc;
    @(posedge clk_1p536m);
    #1;
    dac_req = 1'b0;
  endtask

  task automatic next_req();
    wait_cyc(2);
    issue_req();
  endtask

  task automatic chk_status(input string nm);
    check({nm, "_underrun"}, underrun, m_und);
    check({nm, "_late"}, late, m_late);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_n = 1'b0; dac_req = 1'b0; clr_status = 1'b0; mute = 1'b0;
    src_en = '0; src_vol = '0;
    for (int i = 0; i < NSRC; i++) begin sd[i] = '0; rd_cnt[i] = 0; end
    model_reset();
    wait_cyc(3);
    check("rst_dac_data", dac_data, 0);
    check("rst_dac_chan", dac_chan, 0);
    check("rst_src_rd", src_rd, 0);
    check("rst_underrun", underrun, 0);
    check("rst_late", late, 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Single source, vol 15: priming request aligns the first fetch to L.
    issue_req();                              // #1 out L, fetch R (nothing enabled)
    wait_cyc(12);
    src_en = 3'b001; set_vol(0, 15);
    push(0, 16'sh1000); push(0, -4096);
    next_req();                               // #2 out R, fetch L
    wait_cyc(12);
    next_req();                               // #3 out L
    check("single_L", dac_data, 16'h0F00);
    wait_cyc(12);

    // Saturation with all three sources at full gain.
    src_en = 3'b111;
    for (int i = 0; i < NSRC; i++) begin set_vol(i, 15); push(i, 28672); end
    next_req();                               // #4 out R
    check("single_R", dac_data, 16'hF100);
    wait_cyc(12);
    for (int i = 0; i < NSRC; i++) push(i, 0);
    next_req();                               // #5 out L
    check("sat_pos", dac_data, 16'h7FFF);
    wait_cyc(12);
    for (int i = 0; i < NSRC; i++) push(i, -28672);
    next_req();                               // #6
    wait_cyc(12);
    for (int i = 0; i < NSRC; i++) push(i, 0);
    next_req();                               // #7 out L
    check("sat_neg", dac_data, 16'h8000);
    check("no_underrun_yet", underrun, 0);
    wait_cyc(12);

    // Underrun on source 1: L sample is repeated from the hold.
    src_en = 3'b010; set_vol(1, 8);
    push(1, 16'sh0400);
    next_req();                               // #8 fetch L
    wait_cyc(12);
    push(1, 0);
    next_req();                               // #9 out L
    check("undr_first_L", dac_data, 16'h0200);
    wait_cyc(12);
    next_req();                               // #10 fetch L from empty FIFO
    wait_cyc(12);
    check("undr_flag", underrun, 3'b010);
    src_en = 3'b000;
    next_req();                               // #11 out L repeated
    check("undr_repeat_L", dac_data, 16'h0200);
    wait_cyc(12);
    clr_status = 1'b1; m_und = '0; m_late = 1'b0;
    wait_cyc(1);
    clr_status = 1'b0;
    check("undr_cleared", underrun, 3'b000);
    chk_status("after_clr");

    // Disabled source with data waiting, then master mute.
    src_en = 3'b100; set_vol(2, 15); set_vol(0, 15);
    push(0, 16'sh0800); push(0, 16'sh0400); push(0, 16'sh0200);
    for (int k = 0; k < 4; k++) push(2, 256);
    snap = rd_cnt[0];
    next_req();                               // #12
    wait_cyc(12);
    next_req();                               // #13 out L
    check("src2_L", dac_data, 16'h00F0);
    wait_cyc(12);
    check("dis_no_rd", rd_cnt[0], snap);
    check("dis_fifo_kept", fq[0].size(), 3);
    check("dis_no_underrun", underrun, 0);
    mute = 1'b1;
    next_req();                               // #14
    wait_cyc(12);
    next_req();                               // #15
    check("mute_out", dac_data, 0);
    wait_cyc(12);
    mute = 1'b0;

    // Late request 3 cycles after the previous one, with clr_status on the same edge.
    src_en = 3'b001;
    next_req();                               // #16 fetch L 0x0800
    wait_cyc(12);
    next_req();                               // #17 out L
    check("pre_late_L", dac_data, 16'h0780);
    wait_cyc(2);
    clr_status = 1'b1; m_und = '0; m_late = 1'b0;
    issue_req();                              // #18 late
    clr_status = 1'b0;
    check("late_stale", dac_data, 16'h0780);
    check("late_set_wins", late, 1);
    check("late_restart_rd0", src_rd, 3'b001);
    wait_cyc(12);
    chk_status("after_late");
    next_req();                               // #19

    // Reset in the middle of CAP(1).
    wait_cyc(12);
    src_en = 3'b110; set_vol(1, 15);
    push(1, 256); push(2, 256);
    next_req();                               // #20
    wait_cyc(3);
    snap = rd_cnt[2];
    rst_n = 1'b0;
    #1;
    check("midrst_dac_data", dac_data, 0);
    check("midrst_dac_chan", dac_chan, 0);
    check("midrst_src_rd", src_rd, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_late", late, 0);
    wait_cyc(4);
    check("midrst_no_more_rd", rd_cnt[2], snap);
    model_reset();
    src_en = 3'b000;
    rst_n = 1'b1;
    wait_cyc(2);
    next_req();                               // first after reset
    check("post_rst_data", dac_data, 0);
    check("post_rst_chan", dac_chan, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 120; n++) begin
      wait_cyc($urandom_range(10, 16));
      if ($urandom_range(0, 5) == 0) begin
        clr_status = 1'b1;
        wait_cyc(1);
        clr_status = 1'b0;
        m_und = '0; m_late = 1'b0;
      end
      chk_status("rand");
      src_en = NSRC'($urandom_range(0, 7));
      for (int i = 0; i < NSRC; i++) begin
        set_vol(i, $urandom_range(0, 15));
        repeat ($urandom_range(0, 2)) push(i, int'($urandom_range(0, 65535)) - 32768);
      end
      mute = ($urandom_range(0, 7) == 0);
      next_req();
    end
    wait_cyc(12);
    chk_status("final");
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_mix_ctrl.md
AUDIO_MIX_CTRL -- requirements
Module: audio_mix_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 3, meaning number of sample sources.
REQ-002 SHALL have parameter VOLW, default 4, meaning per-source volume width.
REQ-003 SHALL have port clk_1p536m  in  1  bit clock, shared with the DAC serializer.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dac_req  in  1  serializer sample request: 1-cycle pulse, two per 32-cycle frame (L then R).
REQ-006 SHALL have port dac_data  out  16  mixed signed sample presented to the serializer.
REQ-007 SHALL have port dac_chan  out  1  channel of the current dac_data: 0 = L, 1 = R.
REQ-008 SHALL have port src_empty  in  NSRC  per-source FIFO empty.
REQ-009 SHALL have port src_rd  out  NSRC  per-source FIFO read strobe; data is valid on the following cycle.
REQ-010 SHALL have port src_data  in  NSRC*16  per-source signed samples, interleaved L,R.
REQ-011 SHALL have port src_en  in  NSRC  per-source enable.
REQ-012 SHALL have port src_vol  in  NSRC*VOLW  per-source gain (0 = mute).
REQ-013 SHALL have port mute  in  1  master mute.
REQ-014 SHALL have port clr_status  in  1  clears the sticky flags.
REQ-015 SHALL have port underrun  out  NSRC  sticky: an enabled source was empty when fetched.
REQ-016 SHALL have port late  out  1  sticky: dac_req arrived before the mix completed.

Function
REQ-017 SHALL implement states IDLE, RD(i), CAP(i), SAT, with i = 0..NSRC-1.
- Transitions: IDLE -dac_req-> RD(0) -> CAP(0) -> RD(1) ... CAP(NSRC-1) -> SAT -> IDLE.
- For NSRC=3, the mix is complete 7 cycles after dac_req.
REQ-018 On the edge sampling dac_req=1, SHALL load dac_data <= next_r and dac_chan <= next_chan, toggle next_chan, clear the accumulator, and enter RD(0).
- dac_data SHALL change on no other edge.
REQ-019 In RD(i), SHALL assert src_rd[i] for exactly one cycle iff src_en[i] && !src_empty[i].
REQ-020 In CAP(i), the source contribution SHALL be as follows.
- Read issued: capture src_data[i] into hold[i][next_chan].
- Enabled but empty: reuse hold[i][next_chan] and set underrun[i].
- Disabled: contribute 0, leave hold unchanged, no underrun.
REQ-021 In CAP(i), SHALL add (sample * src_vol[i]) >>> VOLW (signed arithmetic shift) into an accumulator of width 16+VOLW+clog2(NSRC)+1; src_vol SHALL be sampled in CAP(i).
REQ-022 SAT SHALL saturate the accumulator to [-32768, 32767] into next_r, or load 0 if mute=1.
REQ-023 A dac_req outside IDLE SHALL still load dac_data <= next_r (the stale mix) and set late.
- The sequence SHALL restart at RD(0) for the new channel.
- The aborted channel's src_rd strobes already issued SHALL stand.
REQ-024 On the same edge, a set event SHALL win over clr_status; otherwise clr_status SHALL clear underrun and late on the next edge.
REQ-025 At most one src_rd bit SHALL be high in any cycle.

Reset
REQ-026 While rst_n=0, the following SHALL hold asynchronously:
- dac_data=0, dac_chan=0, src_rd=0, underrun=0, late=0;
- next_r=0, next_chan=0 (first output is L);
- all hold registers = 0, accumulator = 0, state = IDLE.
REQ-027 A reset mid-sequence SHALL abandon the sequence with no further src_rd; the first dac_req after release SHALL output 0 on L.

Structure
REQ-028 Package audio_mix_pkg SHALL hold the state enum, SAMPLE_W=16, and the saturation limits SAT_MAX/SAT_MIN.
REQ-029 Saturation SHALL be a sub-module audio_mix_sat (accumulator in, 16-bit signed out, combinational); all other logic SHALL stay in audio_mix_ctrl.

Verification
REQ-030 Single source: source 0 with vol=15, L=16'h1000, R=16'hF000 queued -> dac_data L=16'h0F00, R=16'hF100 on consecutive requests.
REQ-031 Saturation: three sources, each L=16'h7000, vol=15 -> dac_data=16'h7FFF; each L=16'h9000 -> 16'h8000.
REQ-032 Underrun: source 1 enabled, L=16'h0400 then empty on the next L fetch, vol=8 -> the next L output repeats 16'h0200 and underrun=3'b010; clr_status -> 3'b000.
REQ-033 Disabled/mute: src_en=0 on a source that is not empty -> its src_rd is never asserted and no underrun is flagged; mute=1 -> dac_data=0 from the next request.
REQ-034 Late request: dac_req 3 cycles after the previous one -> late=1, dac_data=previous next_r, and the sequence restarts at RD(0).
REQ-035 Reset mid-CAP(1): assert rst_n=0 -> all outputs 0 immediately; after release, the first request gives dac_data=0 and dac_chan=0.
